// File: rtl/transpose_pkg.sv
// Shared types and constants for the transpose RAM read/write engine.
package transpose_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef logic bank_t;

  typedef enum logic [1:0] {W_IDLE, W_RUN, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN, R_DONE} r_state_t;
endpackage

// File: rtl/ram_manage_if.sv
// Ping-pong manager handshake: command pulses in, per-bank finish pulses out.
interface ram_manage_if;
  logic wr_command;
  logic wr_ram_number;
  logic rd_command;
  logic rd_ram_number;
  logic wr_finish_0;
  logic wr_finish_1;
  logic rd_finish_0;
  logic rd_finish_1;

  modport s_manage (
    input  wr_command, wr_ram_number, rd_command, rd_ram_number,
    output wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1
  );
  modport m_manage (
    output wr_command, wr_ram_number, rd_command, rd_ram_number,
    input  wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1
  );
endinterface

// File: rtl/ram_wrd_if.sv
// Simple dual-port RAM bank port: write side plus read side with rd_valid return.
interface ram_wrd_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport m_ram (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );
  modport s_ram (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/rd_skid_fifo.sv
// Small show-ahead FIFO that absorbs RAM read returns; head is zero while empty.
module rd_skid_fifo
  import transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign do_push   = push && (count_reg != FULL_CNT);
  assign do_pop    = pop && (count_reg != '0);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
        2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/transpose_rw_engine.sv
// Writes a row-major matrix into a selected bank, reads a bank back column-major.
module transpose_rw_engine
  import transpose_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 512,
  parameter int COLS       = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_manage_if.s_manage        manage,
  ram_wrd_if.m_ram              ram0,
  ram_wrd_if.m_ram              ram1,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST   = ADDR_WIDTH'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST   = ADDR_WIDTH'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] TOTAL_LAST = ADDR_WIDTH'(ROWS * COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE      = ADDR_WIDTH'(1);

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  bank_t                 wr_bank_reg, rd_bank_reg, rd_bank_sel;
  logic [ADDR_WIDTH-1:0] w_row_reg, w_col_reg, w_base_reg;
  logic [ADDR_WIDTH-1:0] r_row_reg, r_col_reg, r_base_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, rd_addr_reg, out_cnt_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [1:0]            wr_en_reg, wr_en_next, wr_finish_reg, wr_finish_next;
  logic [1:0]            rd_en_reg, rd_en_next, rd_finish_reg, rd_finish_next;
  logic [FIFO_CNT_W-1:0] outstanding_reg, fifo_count;
  logic                  wr_start, w_hs, w_last;
  logic                  rd_issue, rd_end, r_last, rd_credit, out_hs, o_last;
  logic                  ret_valid, fifo_empty;
  logic [DATA_WIDTH-1:0] ret_data;

  assign in_ready  = (w_state_reg == W_RUN);
  assign w_hs      = in_ready && in_valid;
  assign w_last    = (w_row_reg == ROW_LAST) && (w_col_reg == COL_LAST);
  assign r_last    = (r_row_reg == ROW_LAST) && (r_col_reg == COL_LAST);
  assign out_valid = !fifo_empty;
  assign out_hs    = out_valid && out_ready;
  assign o_last    = (out_cnt_reg == TOTAL_LAST);
  // Outstanding reads reserve FIFO slots so returns can never overflow it.
  assign rd_credit = (outstanding_reg + fifo_count) < FIFO_CNT_W'(FIFO_DEPTH);
  assign rd_bank_sel = (r_state_reg == R_IDLE) ? manage.rd_ram_number : rd_bank_reg;
  assign ret_valid = (rd_bank_reg ? ram1.rd_valid : ram0.rd_valid) && (outstanding_reg != '0);
  assign ret_data  = rd_bank_reg ? ram1.rd_data : ram0.rd_data;

  always_comb begin
    w_state_next = w_state_reg;
    wr_start     = 1'b0;
    case (w_state_reg)
      // A pending finish pulse means the previous write is still closing out.
      W_IDLE: if (manage.wr_command && (wr_finish_reg == 2'b00)) begin
        wr_start     = 1'b1;
        w_state_next = W_RUN;
      end
      W_RUN:   if (w_hs && w_last) w_state_next = W_DONE;
      W_DONE:  w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    rd_issue     = 1'b0;
    rd_end       = 1'b0;
    case (r_state_reg)
      R_IDLE: if (manage.rd_command) begin
        rd_issue     = 1'b1;
        r_state_next = r_last ? R_DRAIN : R_ISSUE;
      end
      R_ISSUE: if (rd_credit) begin
        rd_issue = 1'b1;
        if (r_last) r_state_next = R_DRAIN;
      end
      R_DRAIN: if (out_hs && o_last) begin
        rd_end       = 1'b1;
        r_state_next = R_DONE;
      end
      R_DONE:  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign wr_en_next[gi]     = w_hs && (wr_bank_reg == bank_t'(gi));
    assign wr_finish_next[gi] = (w_state_reg == W_DONE) && (wr_bank_reg == bank_t'(gi));
    assign rd_en_next[gi]     = rd_issue && (rd_bank_sel == bank_t'(gi));
    assign rd_finish_next[gi] = rd_end && (rd_bank_reg == bank_t'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      wr_bank_reg <= 1'b0;
      w_row_reg   <= '0;
      w_col_reg   <= '0;
      w_base_reg  <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_en_reg   <= '0;
      wr_finish_reg <= '0;
    end else begin
      w_state_reg   <= w_state_next;
      wr_en_reg     <= wr_en_next;
      wr_finish_reg <= wr_finish_next;
      if (wr_start) begin
        wr_bank_reg <= manage.wr_ram_number;
        w_row_reg   <= '0;
        w_col_reg   <= '0;
        w_base_reg  <= '0;
      end else if (w_hs) begin
        wr_addr_reg <= w_base_reg + w_col_reg;
        wr_data_reg <= in_data;
        if (w_col_reg == COL_LAST) begin
          w_col_reg  <= '0;
          w_row_reg  <= w_row_reg + A_ONE;
          w_base_reg <= w_base_reg + COLS_A;
        end else begin
          w_col_reg <= w_col_reg + A_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg     <= R_IDLE;
      rd_bank_reg     <= 1'b0;
      r_row_reg       <= '0;
      r_col_reg       <= '0;
      r_base_reg      <= '0;
      rd_addr_reg     <= '0;
      rd_en_reg       <= '0;
      rd_finish_reg   <= '0;
      out_cnt_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      r_state_reg   <= r_state_next;
      rd_en_reg     <= rd_en_next;
      rd_finish_reg <= rd_finish_next;
      if (r_state_reg == R_IDLE && manage.rd_command) rd_bank_reg <= manage.rd_ram_number;
      // Row index runs fastest so the bank is walked column by column.
      if (rd_issue) begin
        rd_addr_reg <= r_base_reg + r_col_reg;
        if (r_row_reg == ROW_LAST) begin
          r_row_reg  <= '0;
          r_base_reg <= '0;
          r_col_reg  <= r_col_reg + A_ONE;
        end else begin
          r_row_reg  <= r_row_reg + A_ONE;
          r_base_reg <= r_base_reg + COLS_A;
        end
      end else if (r_state_reg == R_DONE) begin
        r_row_reg  <= '0;
        r_col_reg  <= '0;
        r_base_reg <= '0;
      end
      if (r_state_reg == R_DONE) out_cnt_reg <= '0;
      else if (out_hs)           out_cnt_reg <= out_cnt_reg + A_ONE;
      case ({rd_issue, ret_valid})
        2'b10:   outstanding_reg <= outstanding_reg + FIFO_CNT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - FIFO_CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  rd_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_valid),
    .push_data (ret_data),
    .pop       (out_hs),
    .head_data (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ram0.wr_en   = wr_en_reg[0];
  assign ram0.wr_addr = wr_addr_reg;
  assign ram0.wr_data = wr_data_reg;
  assign ram0.rd_en   = rd_en_reg[0];
  assign ram0.rd_addr = rd_addr_reg;
  assign ram1.wr_en   = wr_en_reg[1];
  assign ram1.wr_addr = wr_addr_reg;
  assign ram1.wr_data = wr_data_reg;
  assign ram1.rd_en   = rd_en_reg[1];
  assign ram1.rd_addr = rd_addr_reg;

  assign manage.wr_finish_0 = wr_finish_reg[0];
  assign manage.wr_finish_1 = wr_finish_reg[1];
  assign manage.rd_finish_0 = rd_finish_reg[0];
  assign manage.rd_finish_1 = rd_finish_reg[1];
endmodule

// File: tb/tb_transpose_rw_engine.sv
// Directed bench for transpose_rw_engine on a 3x4 matrix with behavioural RAM banks.
module tb_transpose_rw_engine;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  ram_manage_if mgr ();
  ram_wrd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0 ();
  ram_wrd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1 ();

  transpose_rw_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .manage    (mgr),
    .ram0      (r0),
    .ram1      (r1),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural RAM banks with selectable read latency (lsel = latency-1).
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];
  logic [2:0]    pv0, pv1;
  logic [DW-1:0] pd0 [3];
  logic [DW-1:0] pd1 [3];
  logic [1:0]    lsel = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      pv0 <= '0;
      pv1 <= '0;
    end else begin
      pv0 <= {pv0[1:0], r0.rd_en};
      pv1 <= {pv1[1:0], r1.rd_en};
      pd0[0] <= mem0[r0.rd_addr]; pd0[1] <= pd0[0]; pd0[2] <= pd0[1];
      pd1[0] <= mem1[r1.rd_addr]; pd1[1] <= pd1[0]; pd1[2] <= pd1[1];
      if (r0.wr_en) mem0[r0.wr_addr] <= r0.wr_data;
      if (r1.wr_en) mem1[r1.wr_addr] <= r1.wr_data;
    end
  end
  assign r0.rd_valid = pv0[lsel];
  assign r0.rd_data  = pd0[lsel];
  assign r1.rd_valid = pv1[lsel];
  assign r1.rd_data  = pd1[lsel];

  // Cycle-level monitor; also drives out_ready and logs each output transaction.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr0_n = 0, wr1_n = 0, rd1_n = 0, wf0_n = 0, wf1_n = 0, rf0_n = 0, rf1_n = 0;
  int last_wr_cyc = 0, wf_cyc = 0, rf_cyc = 0, last_pop_cyc = 0;
  int issued = 0, popped = 0, max_fly = 0;
  int ready_mode = 0;
  logic [DW-1:0] outq [$];

  always @(negedge clk) begin
    if (r0.wr_en) begin wr0_n++; last_wr_cyc = cyc; end
    if (r1.wr_en) begin wr1_n++; last_wr_cyc = cyc; end
    if (r1.rd_en) rd1_n++;
    if (mgr.wr_finish_0) begin wf0_n++; wf_cyc = cyc; end
    if (mgr.wr_finish_1) begin wf1_n++; wf_cyc = cyc; end
    if (mgr.rd_finish_0) begin rf0_n++; rf_cyc = cyc; end
    if (mgr.rd_finish_1) begin rf1_n++; rf_cyc = cyc; end
    if (rst) begin
      issued = 0;
      popped = 0;
    end else begin
      if (r0.rd_en || r1.rd_en) issued++;
      if (issued - popped > max_fly) max_fly = issued - popped;
    end
    out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (out_valid && out_ready) begin
      outq.push_back(out_data);
      popped++;
      last_pop_cyc = cyc;
      $display("out #%0d data=%0d", outq.size() - 1, out_data);
    end
  end

  int exp_seq [N] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
  int gaps [N] = '{0, 5, 1, 0, 3, 2, 4, 0, 5, 1, 2, 0};
  int sent_n = 0;

  task automatic wr_cmd(input logic bank);
    mgr.wr_command = 1'b1;
    mgr.wr_ram_number = bank;
    @(negedge clk);
    mgr.wr_command = 1'b0;
  endtask

  task automatic rd_cmd(input logic bank);
    mgr.rd_command = 1'b1;
    mgr.rd_ram_number = bank;
    @(negedge clk);
    mgr.rd_command = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data = v;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    sent_n++;
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (outq.size() < target && t < 2000) begin @(negedge clk); t++; end
    check("out_arrival", 32'(outq.size() >= target), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base);
    for (int i = 0; i < N; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(outq[base + i]), 32'(exp_seq[i]));
  endtask

  int b_wr0, b_wr1, b_rd1, b_wf0, b_wf1, b_rf0, b_rf1, base, b_sent;

  task automatic snap();
    b_wr0 = wr0_n; b_wr1 = wr1_n; b_rd1 = rd1_n;
    b_wf0 = wf0_n; b_wf1 = wf1_n; b_rf0 = rf0_n; b_rf1 = rf1_n;
    base = outq.size(); b_sent = sent_n;
  endtask

  initial begin
    mgr.wr_command = 1'b0; mgr.wr_ram_number = 1'b0;
    mgr.rd_command = 1'b0; mgr.rd_ram_number = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out", 32'({out_valid, out_data}), 32'd0);
    check("rst_ram0", 32'({r0.wr_en, r0.rd_en, r0.wr_addr, r0.rd_addr, r0.wr_data}), 32'd0);
    check("rst_ram1", 32'({r1.wr_en, r1.rd_en, r1.wr_addr, r1.rd_addr, r1.wr_data}), 32'd0);
    check("rst_fin", 32'({mgr.wr_finish_0, mgr.wr_finish_1, mgr.rd_finish_0, mgr.rd_finish_1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write 0..11 into bank 0 back-to-back.
    snap();
    wr_cmd(1'b0);
    check("wrA_in_ready_rise", 32'(in_ready), 32'd1);
    for (int k = 0; k < N; k++) send(DW'(k), 0);
    check("wrA_in_ready_drop", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("wrA_wr_en_count", 32'(wr0_n - b_wr0), 32'd12);
    check("wrA_ram1_quiet", 32'(wr1_n - b_wr1 + rd1_n - b_rd1), 32'd0);
    check("wrA_finish0", 32'(wf0_n - b_wf0), 32'd1);
    check("wrA_finish1", 32'(wf1_n - b_wf1), 32'd0);
    check("wrA_finish_time", 32'(wf_cyc - last_wr_cyc), 32'd1);
    for (int k = 0; k < N; k++) check($sformatf("wrA_mem0[%0d]", k), 32'(mem0[k]), 32'(k));

    // Read bank 0, latency 1, always ready.
    lsel = 2'd0; ready_mode = 0;
    snap();
    rd_cmd(1'b0);
    check("rdB_first_rd_en", 32'(r0.rd_en), 32'd1);
    wait_out(base + N);
    repeat (4) @(negedge clk);
    check_seq("rdB", base);
    check("rdB_count", 32'(outq.size() - base), 32'd12);
    check("rdB_finish0", 32'(rf0_n - b_rf0), 32'd1);
    check("rdB_finish1", 32'(rf1_n - b_rf1), 32'd0);
    check("rdB_finish_time", 32'(rf_cyc - last_pop_cyc), 32'd1);

    // Read bank 0, latency 3, random backpressure.
    lsel = 2'd2; ready_mode = 1;
    snap();
    rd_cmd(1'b0);
    wait_out(base + N);
    repeat (8) @(negedge clk);
    check_seq("rdC", base);
    check("rdC_count", 32'(outq.size() - base), 32'd12);
    check("rdC_finish0", 32'(rf0_n - b_rf0), 32'd1);
    check("rdC_inflight_le4", 32'(max_fly <= 4), 32'd1);

    // Write bank 1 with gaps while reading bank 0; a stray wr_command mid-write.
    snap();
    wr_cmd(1'b1);
    rd_cmd(1'b0);
    for (int k = 0; k < N; k++) begin
      if (k == 5) wr_cmd(1'b0);
      send(DW'(100 + k), gaps[k]);
    end
    wait_out(base + N);
    repeat (8) @(negedge clk);
    check_seq("conD", base);
    check("conD_sent", 32'(sent_n - b_sent), 32'd12);
    check("conD_wr1_count", 32'(wr1_n - b_wr1), 32'd12);
    check("conD_wr0_quiet", 32'(wr0_n - b_wr0), 32'd0);
    check("conD_wfin", 32'({8'(wf0_n - b_wf0), 8'(wf1_n - b_wf1)}), 32'h0001);
    check("conD_rfin", 32'({8'(rf0_n - b_rf0), 8'(rf1_n - b_rf1)}), 32'h0100);
    for (int k = 0; k < N; k++) check($sformatf("conD_mem1[%0d]", k), 32'(mem1[k]), 32'(100 + k));

    // Reset in the middle of a read, then restart it.
    lsel = 2'd0; ready_mode = 0;
    snap();
    rd_cmd(1'b0);
    wait_out(base + 5);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstE_out", 32'({out_valid, out_data}), 32'd0);
    check("rstE_ram0", 32'({r0.wr_en, r0.rd_en, r0.wr_addr, r0.rd_addr, r0.wr_data}), 32'd0);
    check("rstE_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstE_no_finish", 32'(rf0_n - b_rf0 + rf1_n - b_rf1), 32'd0);
    snap();
    rd_cmd(1'b0);
    wait_out(base + N);
    repeat (4) @(negedge clk);
    check_seq("rstE_restart", base);
    check("rstE_finish0", 32'(rf0_n - b_rf0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
